// File: rtl/challenge_requester.sv
// -----------------------------------------------------------------------------
// challenge_requester
// Initiator side of the CHALLENGE / CHALLENGE_AUTH exchange of the USB Type-C
// authentication driver. On Start it issues one CHALLENGE request (header plus
// 32-bit nonce) for a certificate slot. It then waits for the responder's
// CHALLENGE_AUTH, checks every field, and reports Pass/Fail with an error code.
//
// Ports
//   clk           clock, all logic on posedge
//   reset_L       asynchronous active-low reset
//   Start         begin an exchange (honoured only in IDLE)
//   Slot[7:0]     certificate slot to challenge (valid 0..7)
//   req_ready     transport accepts the request this cycle
//   req_valid     request header/payload valid
//   req_header    {PROTOCOL_VERSION, CHALLENGE_CMD, slot, 8'h00}
//   req_payload   {zeros, nonce[31:0]}
//   resp_valid    response header/payload valid
//   resp_header   CHALLENGE_AUTH header
//   resp_payload  CHALLENGE_AUTH payload
//   Busy          high in every state except IDLE
//   Done          one-cycle completion pulse
//   Auth_Pass     all response checks passed (valid with Done, then held)
//   Err_code[2:0] 0 ok, 1 version, 2 msg type, 3 slot, 4 mask/payload,
//                 5 timeout, 6 invalid slot
//
// Build option
//   CHALLENGE_RETRY_EN : when defined, a timeout re-sends the request with a
//                        fresh nonce up to RETRY_MAX times before reporting 5.
//
// State | meaning
//   IDLE      | waiting for Start
//   SEND      | request presented, waiting for req_ready
//   WAIT_RESP | request accepted, timing the response
//   REPORT    | one-cycle Done pulse, result registers already updated
// -----------------------------------------------------------------------------

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h01
`endif
`ifndef CHALLENGE_CMD
`define CHALLENGE_CMD 8'h83
`endif
`ifndef CHALLENGE_AUTH_CMD
`define CHALLENGE_AUTH_CMD 8'h03
`endif
`ifndef CERT_CHAINS_MASK
`define CERT_CHAINS_MASK 8'h01
`endif
`ifndef CAPABILITIES
`define CAPABILITIES 8'h02
`endif
`ifndef CHALLENGE_AUTH_HASH
`define CHALLENGE_AUTH_HASH 64'hDEAD_BEEF_CAFE_F00D
`endif
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 8
`endif
`ifndef SIZE_OF_HEADER_IN_BYTES
`define SIZE_OF_HEADER_IN_BYTES 4
`endif
`ifndef MSG_LEN
`define MSG_LEN 128
`endif

module challenge_requester #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned RETRY_MAX      = 2,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1,
    localparam int         HW             = `SIZE_OF_HEADER_VARS * `SIZE_OF_HEADER_IN_BYTES,
    localparam int         PW             = `MSG_LEN - HW
) (
    input  logic          clk,
    input  logic          reset_L,
    input  logic          Start,
    input  logic [7:0]    Slot,
    input  logic          req_ready,
    output logic          req_valid,
    output logic [HW-1:0] req_header,
    output logic [PW-1:0] req_payload,
    input  logic          resp_valid,
    input  logic [HW-1:0] resp_header,
    input  logic [PW-1:0] resp_payload,
    output logic          Busy,
    output logic          Done,
    output logic          Auth_Pass,
    output logic [2:0]    Err_code
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_RESP = 2'd2,
        REPORT    = 2'd3
    } state_t;

    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] PL_PREFIX = {`PROTOCOL_VERSION, `PROTOCOL_VERSION, `CAPABILITIES, 8'h00};

    state_t        state_q, state_d;
    logic [31:0]   lfsr_q;
    logic [31:0]   nonce_q;
    logic [7:0]    slot_q;
    logic [TW-1:0] timer_q;
    logic          expired;
    logic          do_retry;
    logic [2:0]    resp_err;

    assign expired = (timer_q == TIMER_LAST);

`ifdef CHALLENGE_RETRY_EN
    localparam int RW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;
    logic [RW-1:0] retry_cnt_q;

    assign do_retry = expired && (retry_cnt_q < RW'(RETRY_MAX));

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            retry_cnt_q <= '0;
        end else if (state_q == IDLE && Start) begin
            retry_cnt_q <= '0;
        end else if (state_q == WAIT_RESP && !resp_valid && do_retry) begin
            retry_cnt_q <= retry_cnt_q + 1'b1;
        end
    end
`else
    assign do_retry = 1'b0;
`endif

    // First failing check wins; later checks are masked by the if-chain.
    always_comb begin
        resp_err = 3'd0;
        if (resp_header[HW-1-:8] != `PROTOCOL_VERSION) begin
            resp_err = 3'd1;
        end else if (resp_header[HW-9-:8] != `CHALLENGE_AUTH_CMD) begin
            resp_err = 3'd2;
        end else if (resp_header[15:8] != slot_q) begin
            resp_err = 3'd3;
        end else if (resp_header[7:0] != `CERT_CHAINS_MASK ||
                     resp_payload[PW-1-:32] != PL_PREFIX ||
                     resp_payload[PW-33:0] != `CHALLENGE_AUTH_HASH) begin
            resp_err = 3'd4;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_valid   = 1'b0;
        Busy        = 1'b1;
        Done        = 1'b0;
        req_header  = {`PROTOCOL_VERSION, `CHALLENGE_CMD, slot_q, 8'h00};
        req_payload = {{(PW-32){1'b0}}, nonce_q};
        case (state_q)
            IDLE: begin
                Busy = 1'b0;
                if (Start) begin
                    state_d = (Slot > 8'd7) ? REPORT : SEND;
                end
            end
            SEND: begin
                req_valid = 1'b1;
                if (req_ready) begin
                    state_d = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the expiry cycle takes precedence.
                if (resp_valid) begin
                    state_d = REPORT;
                end else if (expired) begin
                    state_d = do_retry ? SEND : REPORT;
                end
            end
            REPORT: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // The LFSR free-runs so the nonce depends on when Start arrives.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            lfsr_q    <= LFSR_SEED;
            nonce_q   <= '0;
            slot_q    <= '0;
            timer_q   <= '0;
            Auth_Pass <= 1'b0;
            Err_code  <= 3'd0;
        end else begin
            lfsr_q <= {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        slot_q    <= Slot;
                        nonce_q   <= lfsr_q;
                        Auth_Pass <= 1'b0;
                        Err_code  <= (Slot > 8'd7) ? 3'd6 : 3'd0;
                    end
                end
                SEND: begin
                    if (req_ready) begin
                        timer_q <= '0;
                    end
                end
                WAIT_RESP: begin
                    if (resp_valid) begin
                        Err_code  <= resp_err;
                        Auth_Pass <= (resp_err == 3'd0);
                    end else if (expired) begin
                        if (do_retry) begin
                            nonce_q <= lfsr_q;
                        end else begin
                            Err_code <= 3'd5;
                        end
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_challenge_requester.sv
`timescale 1ns/1ps

`ifndef PROTOCOL_VERSION
`define PROTOCOL_VERSION 8'h01
`endif
`ifndef CHALLENGE_CMD
`define CHALLENGE_CMD 8'h83
`endif
`ifndef CHALLENGE_AUTH_CMD
`define CHALLENGE_AUTH_CMD 8'h03
`endif
`ifndef CERT_CHAINS_MASK
`define CERT_CHAINS_MASK 8'h01
`endif
`ifndef CAPABILITIES
`define CAPABILITIES 8'h02
`endif
`ifndef CHALLENGE_AUTH_HASH
`define CHALLENGE_AUTH_HASH 64'hDEAD_BEEF_CAFE_F00D
`endif
`ifndef SIZE_OF_HEADER_VARS
`define SIZE_OF_HEADER_VARS 8
`endif
`ifndef SIZE_OF_HEADER_IN_BYTES
`define SIZE_OF_HEADER_IN_BYTES 4
`endif
`ifndef MSG_LEN
`define MSG_LEN 128
`endif

module tb_challenge_requester;

    localparam int          HW   = `SIZE_OF_HEADER_VARS * `SIZE_OF_HEADER_IN_BYTES;
    localparam int          PW   = `MSG_LEN - HW;
    localparam int          TO   = 16;
    localparam logic [31:0] SEED = 32'hACE1;
`ifdef CHALLENGE_RETRY_EN
    localparam int          N_ATTEMPTS = 3;
`else
    localparam int          N_ATTEMPTS = 1;
`endif

    typedef struct {
        logic [HW-1:0] hdr;
        logic [PW-1:0] pay;
        logic          chk_nonce;
    } req_t;

    typedef struct {
        logic       pass;
        logic [2:0] err;
    } resp_t;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          Start = 1'b0;
    logic [7:0]    Slot = 8'd0;
    logic          req_ready = 1'b1;
    logic          req_valid;
    logic [HW-1:0] req_header;
    logic [PW-1:0] req_payload;
    logic          resp_valid = 1'b0;
    logic [HW-1:0] resp_header = '0;
    logic [PW-1:0] resp_payload = '0;
    logic          Busy, Done, Auth_Pass;
    logic [2:0]    Err_code;

    int            n_checks = 0;
    int            n_pass = 0;
    int            xfer_cnt = 0;
    int            exp_xfer = 0;
    req_t          req_q[$];
    resp_t         resp_q[$];
    logic [31:0]   seen_nonce[$];
    logic [31:0]   m_lfsr;

    challenge_requester #(
        .TIMEOUT_CYCLES(TO),
        .RETRY_MAX(2),
        .LFSR_SEED(SEED)
    ) dut (
        .clk(clk),
        .reset_L(reset_L),
        .Start(Start),
        .Slot(Slot),
        .req_ready(req_ready),
        .req_valid(req_valid),
        .req_header(req_header),
        .req_payload(req_payload),
        .resp_valid(resp_valid),
        .resp_header(resp_header),
        .resp_payload(resp_payload),
        .Busy(Busy),
        .Done(Done),
        .Auth_Pass(Auth_Pass),
        .Err_code(Err_code)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    // Reference nonce generator: seed at reset, one step per clock.
    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) m_lfsr <= SEED;
        else          m_lfsr <= lfsr_step(m_lfsr);
    end

    function automatic logic [HW-1:0] good_hdr(input logic [7:0] s);
        return {`PROTOCOL_VERSION, `CHALLENGE_AUTH_CMD, s, `CERT_CHAINS_MASK};
    endfunction

    function automatic logic [PW-1:0] good_pl();
        return {`PROTOCOL_VERSION, `PROTOCOL_VERSION, `CAPABILITIES, 8'h00, `CHALLENGE_AUTH_HASH};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse Start for one cycle; a valid slot also queues the expected request.
    task automatic do_start(input logic [7:0] s);
        req_t r;
        if (s <= 8'd7) begin
            r.hdr       = {`PROTOCOL_VERSION, `CHALLENGE_CMD, s, 8'h00};
            r.pay       = {{(PW-32){1'b0}}, m_lfsr};
            r.chk_nonce = 1'b1;
            req_q.push_back(r);
        end
        Start = 1'b1;
        Slot  = s;
        tick();
        Start = 1'b0;
    endtask

    task automatic expect_resp(input logic p, input logic [2:0] e);
        resp_t x;
        x.pass = p;
        x.err  = e;
        resp_q.push_back(x);
    endtask

    task automatic send_resp(input logic [HW-1:0] h, input logic [PW-1:0] p);
        resp_valid   = 1'b1;
        resp_header  = h;
        resp_payload = p;
        tick();
        resp_valid = 1'b0;
    endtask

    // Start -> one-cycle request -> response -> Done one cycle later.
    task automatic run_exchange(input string name, input logic [7:0] s,
                                input logic [HW-1:0] h, input logic [PW-1:0] p,
                                input logic ep, input logic [2:0] ee);
        do_start(s);
        exp_xfer++;
        chk({name, "_req_valid"}, req_valid, 1'b1);
        tick();
        chk({name, "_req_drop"}, req_valid, 1'b0);
        expect_resp(ep, ee);
        send_resp(h, p);
        chk({name, "_done"}, Done, 1'b1);
        tick();
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_L) begin
            if (req_valid && req_ready) begin
                req_t r;
                xfer_cnt++;
                seen_nonce.push_back(req_payload[31:0]);
                chk("req_expected", req_q.size() != 0, 1'b1);
                if (req_q.size() != 0) begin
                    r = req_q.pop_front();
                    chk("req_header", req_header, r.hdr);
                    if (r.chk_nonce) chk("req_payload", req_payload, r.pay);
                    else             chk("req_payload_hi", req_payload[PW-1:32], '0);
                end
            end
            if (Done) begin
                resp_t x;
                chk("done_expected", resp_q.size() != 0, 1'b1);
                if (resp_q.size() != 0) begin
                    x = resp_q.pop_front();
                    chk("auth_pass", Auth_Pass, x.pass);
                    chk("err_code", Err_code, x.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [HW-1:0] f_hdr[5];
    logic [PW-1:0] f_pl[5];
    logic [2:0]    f_err[5];
    logic [PW-1:0] pl_tmp;
    int            cyc;

    initial begin
        pl_tmp = good_pl();
        f_hdr[0] = {8'hFF, `CHALLENGE_AUTH_CMD, 8'h03, `CERT_CHAINS_MASK};     f_pl[0] = pl_tmp;          f_err[0] = 3'd1;
        f_hdr[1] = {`PROTOCOL_VERSION, 8'h00, 8'h03, `CERT_CHAINS_MASK};       f_pl[1] = pl_tmp;          f_err[1] = 3'd2;
        f_hdr[2] = {`PROTOCOL_VERSION, `CHALLENGE_AUTH_CMD, 8'h05, `CERT_CHAINS_MASK}; f_pl[2] = pl_tmp;  f_err[2] = 3'd3;
        f_hdr[3] = good_hdr(8'h03);                                            f_pl[3] = pl_tmp ^ 1'b1;   f_err[3] = 3'd4;
        f_hdr[4] = {8'hFF, `CHALLENGE_AUTH_CMD, 8'h05, `CERT_CHAINS_MASK};     f_pl[4] = pl_tmp;          f_err[4] = 3'd1;

        repeat (3) @(negedge clk);
        reset_L = 1'b1;
        tick();
        chk("rst_busy", Busy, 1'b0);
        chk("rst_done", Done, 1'b0);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_err", Err_code, 3'd0);
        chk("rst_pass", Auth_Pass, 1'b0);
        chk("rst_payload", req_payload, '0);

        // Happy path, slot 3.
        run_exchange("happy", 8'd3, good_hdr(8'h03), good_pl(), 1'b1, 3'd0);
        chk("happy_idle", Busy, 1'b0);
        chk("happy_pass_hold", Auth_Pass, 1'b1);

        // Field errors.
        for (int i = 0; i < 5; i++) begin
            run_exchange("field", 8'd3, f_hdr[i], f_pl[i], 1'b0, f_err[i]);
            tick();
            chk("field_err_hold", Err_code, f_err[i]);
        end

        // Backpressure: request held stable for 5 cycles, single transfer.
        req_ready = 1'b0;
        do_start(8'd6);
        exp_xfer++;
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", req_valid, 1'b1);
            chk("bp_header", req_header, {`PROTOCOL_VERSION, `CHALLENGE_CMD, 8'h06, 8'h00});
            tick();
        end
        req_ready = 1'b1;
        tick();
        chk("bp_drop", req_valid, 1'b0);
        expect_resp(1'b1, 3'd0);
        send_resp(good_hdr(8'h06), good_pl());
        chk("bp_done", Done, 1'b1);
        tick();

        // Invalid slot: Done one cycle after Start, no request.
        expect_resp(1'b0, 3'd6);
        do_start(8'd8);
        chk("inv_done", Done, 1'b1);
        chk("inv_no_req", req_valid, 1'b0);
        tick();
        chk("inv_err_hold", Err_code, 3'd6);

        // Timeout with no response.
        seen_nonce.delete();
        do_start(8'd1);
        for (int i = 1; i < N_ATTEMPTS; i++) begin
            req_t r;
            r.hdr       = {`PROTOCOL_VERSION, `CHALLENGE_CMD, 8'h01, 8'h00};
            r.pay       = '0;
            r.chk_nonce = 1'b0;
            req_q.push_back(r);
        end
        exp_xfer += N_ATTEMPTS;
        tick();
        expect_resp(1'b0, 3'd5);
        cyc = 0;
        while (!Done && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("timeout_cycles", cyc, N_ATTEMPTS * TO + (N_ATTEMPTS - 1));
        chk("timeout_requests", seen_nonce.size(), N_ATTEMPTS);
`ifdef CHALLENGE_RETRY_EN
        if (seen_nonce.size() == 3) begin
            chk("retry_nonce_01", seen_nonce[0] != seen_nonce[1], 1'b1);
            chk("retry_nonce_12", seen_nonce[1] != seen_nonce[2], 1'b1);
            chk("retry_nonce_02", seen_nonce[0] != seen_nonce[2], 1'b1);
        end
`endif
        tick();

        // Response on the expiry cycle wins over timeout.
        do_start(8'd4);
        exp_xfer++;
        tick();
        repeat (TO - 1) tick();
        expect_resp(1'b1, 3'd0);
        send_resp(good_hdr(8'h04), good_pl());
        chk("expiry_done", Done, 1'b1);
        tick();

        // Start during WAIT_RESP is ignored.
        do_start(8'd2);
        exp_xfer++;
        tick();
        Start = 1'b1;
        Slot  = 8'd5;
        tick();
        Start = 1'b0;
        chk("busy_start_busy", Busy, 1'b1);
        chk("busy_start_no_req", req_valid, 1'b0);
        expect_resp(1'b1, 3'd0);
        send_resp(good_hdr(8'h02), good_pl());
        chk("busy_start_done", Done, 1'b1);
        tick();

        // Reset during SEND abandons the request asynchronously.
        req_ready = 1'b0;
        do_start(8'd7);
        #2;
        reset_L = 1'b0;
        #1;
        chk("rst_mid_valid", req_valid, 1'b0);
        chk("rst_mid_busy", Busy, 1'b0);
        chk("rst_mid_err", Err_code, 3'd0);
        req_q.delete();
        @(negedge clk);
        reset_L   = 1'b1;
        req_ready = 1'b1;
        tick();
        run_exchange("post_rst", 8'd3, good_hdr(8'h03), good_pl(), 1'b1, 3'd0);

        repeat (2) tick();
        chk("xfer_count", xfer_cnt, exp_xfer);
        chk("req_q_empty", req_q.size(), 0);
        chk("resp_q_empty", resp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
